// File: rtl/unidade_controle.sv
// Moore control unit for the memory game: clear, wait for a play, register it, compare it, then advance or finish.
// Optional play timeout (state fim_timeout, code 0xD) is compiled in with UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMA       = 4'h6,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

    estado_t estado;
    estado_t proximo;

    if ((TIMEOUT_CICLOS < 2) || (TIMEOUT_CICLOS > 65535)) begin : g_param_invalido
        $error("TIMEOUT_CICLOS out of range 2..65535");
    end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);
    logic [15:0] cont_espera;

    // Zero in the first cycle of every visit to espera_jogada, so the state lasts TIMEOUT_CICLOS cycles.
    always_ff @(posedge clock) begin
        if (reset || (estado != ESPERA_JOGADA)) begin
            cont_espera <= 16'd0;
        end else begin
            cont_espera <= cont_espera + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:       proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita) begin
                    proximo = REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                end else if (cont_espera == LIMITE) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA_JOGADA;
                end
            end
            REGISTRA:      proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo = FIM_ERRO;
                end else if (fimC) begin
                    proximo = FIM_ACERTO;
                end else begin
                    proximo = PROXIMA;
                end
            end
            PROXIMA:       proximo = ESPERA_JOGADA;
            FIM_ACERTO:    proximo = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:      proximo = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT:   proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:       proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:   registraR = 1'b1;
            PROXIMA:    contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized bench: whole rounds are scripted at play level into a queue of (inputs, expected state) steps,
// then replayed cycle by cycle; outputs and pulse totals are checked against the script.
module tb_unidade_controle;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam int T = 8;
`else
    localparam int T = 5000;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic       ini;
        logic       jog;
        logic       ig;
        logic       fc;
        logic [3:0] est;
    } passo_t;

    passo_t fila[$];
    logic [3:0] atual = 4'h0;
    int exp_conta = 0, exp_reg = 0;
    int obs_conta = 0, obs_reg = 0;
    int total = 0, passou = 0, ciclo = 0;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        total++;
        if (obtido === esperado) passou++;
        else $display("FAIL %s ciclo %0d: obtido %0h esperado %0h", tag, ciclo, obtido, esperado);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} per state code
    function automatic logic [7:0] saidas(input logic [3:0] est);
        case (est)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hE:    return 8'b0000_1010;
            4'hD:    return 8'b0000_1011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic put(input logic rst, input logic ini, input logic jog,
                       input logic ig, input logic fc, input logic [3:0] est);
        passo_t p;
        p = '{rst: rst, ini: ini, jog: jog, ig: ig, fc: fc, est: est};
        fila.push_back(p);
        atual = est;
    endtask

    task automatic reseta(input int n);
        repeat (n) put(1'b1, rb(), rb(), rb(), rb(), 4'h0);
    endtask

    task automatic inicia();
        repeat ($urandom_range(0, 3)) put(1'b0, 1'b0, rb(), rb(), rb(), atual);
        put(1'b0, 1'b1, 1'b1, rb(), rb(), 4'h1);
        put(1'b0, rb(), rb(), rb(), rb(), 4'h2);
    endtask

    // One play: 'gap' idle cycles in espera_jogada, then the pulse; ends in 0x2, 0xA or 0xE
    task automatic joga(input int gap, input logic ok, input logic ultima);
        repeat (gap) put(1'b0, rb(), 1'b0, rb(), rb(), 4'h2);
        put(1'b0, rb(), 1'b1, rb(), rb(), 4'h4);
        put(1'b0, rb(), 1'b1, rb(), rb(), 4'h5);
        exp_reg++;
        put(1'b0, rb(), 1'b1, ok, ultima, !ok ? 4'hE : (ultima ? 4'hA : 4'h6));
        if (ok && !ultima) begin
            exp_conta++;
            put(1'b0, rb(), rb(), rb(), rb(), 4'h2);
        end
    endtask

    task automatic rodada(input int ruim, input int corta);
        inicia();
        for (int p = 0; p < 16; p++) begin
            if (p == corta) begin
                put(1'b0, rb(), 1'b0, rb(), rb(), 4'h2);
                reseta(2);
                return;
            end
            joga($urandom_range(0, 3), p != ruim, p == 15);
            if (p == ruim) return;
        end
    endtask

    task automatic espera_longa();
        inicia();
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        repeat (T - 1) put(1'b0, rb(), 1'b0, rb(), rb(), 4'h2);
        put(1'b0, rb(), 1'b0, rb(), rb(), 4'hD);
        repeat (3) put(1'b0, 1'b0, rb(), rb(), rb(), 4'hD);
        inicia();
        joga(T - 1, 1'b1, 1'b0);
        joga(T - 2, 1'b0, 1'b0);
`else
        repeat (100) put(1'b0, rb(), 1'b0, rb(), rb(), 4'h2);
        joga(0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;

        reseta(2);
        rodada(16, -1);
        rodada(2, -1);
        rodada(16, 5);
        espera_longa();
        repeat (6) rodada($urandom_range(0, 16), $urandom_range(0, 20));
        rodada(16, -1);

        foreach (fila[i]) begin
            reset        = fila[i].rst;
            iniciar      = fila[i].ini;
            jogada_feita = fila[i].jog;
            igual        = fila[i].ig;
            fimC         = fila[i].fc;
            @(posedge clock);
            @(negedge clock);
            ciclo = i;
            verifica("estado_saidas",
                     {20'd0, db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout},
                     {20'd0, fila[i].est, saidas(fila[i].est)});
            obs_conta += int'(contaC);
            obs_reg   += int'(registraR);
        end

        verifica("total_contaC", obs_conta, exp_conta);
        verifica("total_registraR", obs_reg, exp_reg);
        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule
